// File: rtl/pwm_multi_step.sv
// rtl/pwm_multi_step.sv - multi-channel PWM with debounced up/down duty buttons
// Shadow duties are edited by button presses and copied to the active set only at period end.
module pwm_multi_step #(
    parameter int NCH        = 4,
    parameter int PERIOD     = 27000,
    parameter int CW         = 15,
    parameter int STEP       = 2700,
    parameter int DUTY_INIT  = 7000,
    parameter int DEB_CYCLES = 270000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           btn_up,
    input  logic           btn_dn,
    input  logic [2:0]     ch_sel,
    output logic [NCH-1:0] pwm_out,
    output logic           period_start,
    output logic [CW-1:0]  duty_sel
);

    localparam int            DW        = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] PERIOD_M1 = CW'(PERIOD - 1);
    localparam logic [CW-1:0] PERIOD_W  = CW'(PERIOD);
    localparam logic [CW:0]   PERIOD_X  = (CW + 1)'(PERIOD);
    localparam logic [CW-1:0] STEP_W    = CW'(STEP);
    localparam logic [CW:0]   STEP_X    = (CW + 1)'(STEP);
    localparam logic [CW-1:0] INIT_W    = CW'(DUTY_INIT);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    // Sums are formed one bit wider so saturation is decided before any wrap.
    function automatic logic [CW-1:0] step_duty(input logic [CW-1:0] d, input logic up);
        if (up) begin
            return (({1'b0, d} + STEP_X) >= PERIOD_X) ? PERIOD_W : d + STEP_W;
        end
        return ({1'b0, d} > STEP_X) ? d - STEP_W : '0;
    endfunction

    logic [CW-1:0]  c_q, c_d;
    logic [NCH-1:0] pwm_q;
    logic           period_start_q;
    logic [CW-1:0]  shadow_q [NCH];
    logic [CW-1:0]  shadow_d [NCH];
    logic [CW-1:0]  active_q [NCH];

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]     s1_q, s2_q;
    logic [1:0]     deb_q, deb_d;
    logic [1:0]     pulse_q, pulse_d;
    logic [DW-1:0]  cnt_q [2];
    logic [DW-1:0]  cnt_d [2];
    logic           up_ev, dn_ev;

    assign c_d = (c_q == PERIOD_M1) ? '0 : c_q + CW'(1);

    always_comb begin
        deb_d   = deb_q;
        pulse_d = '0;
        for (int b = 0; b < 2; b++) begin
            cnt_d[b] = '0;
            if (s2_q[b] != deb_q[b]) begin
                if (cnt_q[b] == DEB_LAST) begin
                    deb_d[b]   = s2_q[b];
                    pulse_d[b] = s2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + DW'(1);
                end
            end
        end
    end

    assign up_ev = pulse_q[0] & ~pulse_q[1];
    assign dn_ev = pulse_q[1] & ~pulse_q[0];

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            shadow_d[i] = shadow_q[i];
            if ((up_ev || dn_ev) && (ch_sel == 3'(i))) begin
                shadow_d[i] = step_duty(shadow_q[i], up_ev);
            end
        end
    end

    always_comb begin
        duty_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_sel == 3'(i)) begin
                duty_sel = shadow_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_q            <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
            s1_q           <= '0;
            s2_q           <= '0;
            deb_q          <= '0;
            pulse_q        <= '0;
            for (int b = 0; b < 2; b++) begin
                cnt_q[b] <= '0;
            end
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= INIT_W;
                active_q[i] <= INIT_W;
            end
        end else begin
            c_q            <= c_d;
            period_start_q <= (c_q == '0);
            s1_q           <= {btn_dn, btn_up};
            s2_q           <= s1_q;
            deb_q          <= deb_d;
            pulse_q        <= pulse_d;
            for (int b = 0; b < 2; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
            for (int i = 0; i < NCH; i++) begin
                pwm_q[i]    <= (c_q < active_q[i]);
                shadow_q[i] <= shadow_d[i];
                // The copy sees the pre-press shadow, so a coinciding press waits a period.
                if (c_q == PERIOD_M1) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_multi_step.sv
// tb/tb_pwm_multi_step.sv - randomized and directed bench for pwm_multi_step against a behavioural model
module tb_pwm_multi_step;

    localparam int NCH = 2, PERIOD = 10, CW = 4, STEP = 3, DUTY_INIT = 5, DEB = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           btn_up = 1'b0;
    logic           btn_dn = 1'b0;
    logic [2:0]     ch_sel = 3'd0;
    logic [NCH-1:0] pwm_out;
    logic           period_start;
    logic [CW-1:0]  duty_sel;

    pwm_multi_step #(
        .NCH(NCH), .PERIOD(PERIOD), .CW(CW), .STEP(STEP),
        .DUTY_INIT(DUTY_INIT), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .ch_sel(ch_sel),
        .pwm_out(pwm_out), .period_start(period_start), .duty_sel(duty_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counter phase is edges-since-reset modulo PERIOD.
    int n;
    int sh  [NCH];
    int act [NCH];
    bit deb [2];
    int run [2];
    bit pend[2];
    bit hq0[$];
    bit hq1[$];
    int exp_pwm;
    bit exp_ps;

    function automatic void model_reset();
        n = 0;
        for (int i = 0; i < NCH; i++) begin
            sh[i]  = DUTY_INIT;
            act[i] = DUTY_INIT;
        end
        for (int b = 0; b < 2; b++) begin
            deb[b] = 0; run[b] = 0; pend[b] = 0;
        end
        hq0 = '{0, 0};
        hq1 = '{0, 0};
        exp_pwm = 0;
        exp_ps  = 0;
    endfunction

    // Button b is seen two edges late; a press event fires after DEB straight differing samples.
    function automatic bit deb_step(input int b, input bit raw);
        bit sy;
        if (b == 0) begin sy = hq0.pop_front(); hq0.push_back(raw); end
        else        begin sy = hq1.pop_front(); hq1.push_back(raw); end
        if (sy != deb[b]) begin
            run[b]++;
            if (run[b] == DEB) begin
                deb[b] = sy;
                run[b] = 0;
                return sy;
            end
        end else begin
            run[b] = 0;
        end
        return 0;
    endfunction

    always begin
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            int c;
            bit nu, nd;
            c = n % PERIOD;
            exp_pwm = 0;
            for (int i = 0; i < NCH; i++) begin
                if (c < act[i]) exp_pwm |= (1 << i);
            end
            exp_ps = (c == 0);
            if (c == PERIOD - 1) begin
                for (int i = 0; i < NCH; i++) act[i] = sh[i];
            end
            if ((pend[0] != pend[1]) && (ch_sel < NCH)) begin
                if (pend[0]) sh[ch_sel] = (sh[ch_sel] + STEP > PERIOD) ? PERIOD : sh[ch_sel] + STEP;
                else         sh[ch_sel] = (sh[ch_sel] < STEP) ? 0 : sh[ch_sel] - STEP;
            end
            nu = deb_step(0, btn_up);
            nd = deb_step(1, btn_dn);
            pend[0] = nu;
            pend[1] = nd;
            n++;
        end
        #1;
        chk("pwm_out", 32'(pwm_out), exp_pwm);
        chk("period_start", 32'(period_start), int'(exp_ps));
        chk("duty_sel", 32'(duty_sel), (ch_sel < NCH) ? sh[ch_sel] : 0);
    end

    task automatic press(input bit up, input bit dn, input int hold);
        @(negedge clk);
        btn_up = up;
        btn_dn = dn;
        repeat (hold) @(negedge clk);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_ps();
        int k;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!period_start && k < 40);
        chk("period_start_seen", 32'(period_start), 1);
    endtask

    task automatic count_period(output int h0, output int h1, output int ps);
        h0 = 0; h1 = 0; ps = 0;
        wait_ps();
        for (int i = 0; i < PERIOD; i++) begin
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            ps += int'(period_start);
            if (i != PERIOD - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    int h0, h1, ps;
    int up_exp[4] = '{8, 10, 10, 10};
    int dn_exp[4] = '{7, 4, 1, 0};
    int cnt1, cnt2, ul, dl;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_pwm", 32'(pwm_out), 0);
        chk("reset_ps", 32'(period_start), 0);
        chk("reset_duty", 32'(duty_sel), 5);

        @(negedge clk);
        rst = 1'b1;
        count_period(h0, h1, ps);
        chk("p1_high0", h0, 5); chk("p1_high1", h1, 5); chk("p1_ps", ps, 1);
        count_period(h0, h1, ps);
        chk("p2_high0", h0, 5); chk("p2_high1", h1, 5); chk("p2_ps", ps, 1);

        ch_sel = 3'd1;
        press(1, 0, 8);
        chk("ch1_up_duty", 32'(duty_sel), 8);
        count_period(h0, h1, ps);
        chk("ch1_high1", h1, 8); chk("ch1_high0", h0, 5);

        @(negedge clk); btn_up = 1'b1;
        repeat (3) @(negedge clk); btn_up = 1'b0;
        repeat (2) @(negedge clk); btn_up = 1'b1;
        repeat (3) @(negedge clk); btn_up = 1'b0;
        repeat (12) @(negedge clk);
        chk("bounce_duty", 32'(duty_sel), 8);

        ch_sel = 3'd0;
        for (int i = 0; i < 4; i++) begin
            press(1, 0, 8);
            chk($sformatf("up%0d_duty", i), 32'(duty_sel), up_exp[i]);
        end
        count_period(h0, h1, ps);
        chk("full_high0", h0, 10);
        for (int i = 0; i < 4; i++) begin
            press(0, 1, 8);
            chk($sformatf("dn%0d_duty", i), 32'(duty_sel), dn_exp[i]);
        end
        count_period(h0, h1, ps);
        chk("zero_high0", h0, 0);

        // Press timed so its pulse lands on the last count of a period.
        wait_ps();
        @(posedge clk); @(posedge clk);
        @(negedge clk); btn_up = 1'b1;
        cnt1 = 0; cnt2 = 0;
        for (int k = 3; k <= 29; k++) begin
            @(posedge clk); #1;
            if (k >= 10 && k <= 19) cnt1 += int'(pwm_out[0]);
            if (k >= 20)            cnt2 += int'(pwm_out[0]);
            if (k == 10) begin
                @(negedge clk); btn_up = 1'b0;
            end
        end
        chk("late_press_old_period", cnt1, 0);
        chk("late_press_new_period", cnt2, 3);
        chk("late_press_duty", 32'(duty_sel), 3);
        repeat (10) @(negedge clk);

        press(1, 1, 8);
        chk("both_duty", 32'(duty_sel), 3);

        ch_sel = 3'd5;
        press(1, 0, 8);
        chk("invalid_ch_duty", 32'(duty_sel), 0);
        ch_sel = 3'd0; #1;
        chk("invalid_ch0_kept", 32'(duty_sel), 3);
        ch_sel = 3'd1; #1;
        chk("invalid_ch1_kept", 32'(duty_sel), 8);

        @(negedge clk); ch_sel = 3'd0; btn_up = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; #1;
        chk("mid_reset_pwm", 32'(pwm_out), 0);
        chk("mid_reset_ps", 32'(period_start), 0);
        chk("mid_reset_duty0", 32'(duty_sel), 5);
        @(negedge clk);
        rst = 1'b1; btn_up = 1'b0;
        repeat (15) @(negedge clk);
        chk("post_reset_duty0", 32'(duty_sel), 5);
        ch_sel = 3'd1; #1;
        chk("post_reset_duty1", 32'(duty_sel), 5);

        ul = 0; dl = 0;
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            if (ul == 0) begin btn_up = 1'($urandom_range(0, 1)); ul = $urandom_range(1, 9); end
            else ul--;
            if (dl == 0) begin btn_dn = 1'($urandom_range(0, 1)); dl = $urandom_range(1, 9); end
            else dl--;
            if ($urandom_range(0, 3) == 0) ch_sel = 3'($urandom_range(0, 3));
        end
        btn_up = 1'b0; btn_dn = 1'b0;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
